// File: rtl/note_lane_engine.sv
`timescale 1ns/1ps
// note_lane_engine
//   N-lane falling-note engine. Each lane spawns a note at the top of the
//   screen, advances it on speed ticks, judges rising button edges against
//   the hit window, and reports misses when the note leaves the screen.
//   Also produces registered per-lane note pixels for the painter.
//   Optional build macro: NOTE_LANE_BADPRESS_MISS_EN -- when defined, a
//   button press while the lane is idle or the note is outside the hit
//   window also counts as a miss.
//   Debug outputs dbg_state_o / dbg_y_o expose every lane's FSM state
//   (1 = FALL) and note position.
//   Handshake: no valid/ready pairs; spawn/button/tick are sampled every
//   cycle and hit/miss are single-cycle registered pulses.
module note_lane_engine #(
    parameter int LANES    = 5,
    parameter int Y_W      = 10,
    parameter int SCREEN_H = 480,
    parameter int HIT_Y    = 384,
    parameter int HIT_WIN  = 16,
    parameter int NOTE_H   = 32,
    parameter int LANE_X0  = 64,
    parameter int LANE_W   = 96,
    parameter int STEP     = 4,
    parameter int MAX_MISS = 8,
    parameter int SCORE_W  = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 tick,
    input  logic [1:0]           level,
    input  logic [LANES-1:0]     spawn,
    input  logic [LANES-1:0]     button,
    input  logic                 video_on,
    input  logic [Y_W-1:0]       pixel_x,
    input  logic [Y_W-1:0]       pixel_y,
    output logic [LANES-1:0]     lane_pix,
    output logic [LANES-1:0]     hit,
    output logic [LANES-1:0]     miss,
    output logic [SCORE_W-1:0]   score,
    output logic                 lost,
    output logic [LANES-1:0]     dbg_state_o,
    output logic [LANES*Y_W-1:0] dbg_y_o
);

    typedef enum logic {IDLE = 1'b0, FALL = 1'b1} lane_state_e;

    localparam int PC_W = 4;
    localparam int MC_W = $clog2(MAX_MISS + LANES + 1);

    lane_state_e          state_q [LANES];
    lane_state_e          state_d [LANES];
    logic [Y_W-1:0]       y_q     [LANES];
    logic [Y_W-1:0]       y_d     [LANES];
    logic [Y_W:0]         y_next  [LANES];
    logic [LANES-1:0]     in_win;
    logic [LANES-1:0]     button_q;
    logic [LANES-1:0]     btn_rise;
    logic [LANES-1:0]     hit_q, hit_d;
    logic [LANES-1:0]     miss_q, miss_d;
    logic [LANES-1:0]     lane_pix_q, lane_pix_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [SCORE_W:0]     score_sum;
    logic [MC_W-1:0]      miss_cnt_q, miss_cnt_d, mc_sum;
    logic                 lost_q, lost_d;
    logic                 active;
    logic [Y_W:0]         step;
    logic [Y_W:0]         px, py;

    function automatic logic [PC_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int k = 0; k < LANES; k++) c = c + PC_W'(v[k]);
        return c;
    endfunction

    assign active   = enable & ~lost_q;
    assign btn_rise = button & ~button_q;
    assign px       = {1'b0, pixel_x};
    assign py       = {1'b0, pixel_y};

    // Lines advanced per tick for the current level.
    always_comb begin
        case (level)
            2'd0:    step = (Y_W+1)'(STEP);
            2'd1:    step = (Y_W+1)'(2 * STEP);
            default: step = (Y_W+1)'(3 * STEP);
        endcase
    end

    // Per-lane next state: spawn, hit judgement (pre-tick y), tick advance, off-screen miss.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            state_d[i] = state_q[i];
            y_d[i]     = y_q[i];
            hit_d[i]   = 1'b0;
            miss_d[i]  = 1'b0;
            y_next[i]  = {1'b0, y_q[i]} + step;
            in_win[i]  = (({2'b0, y_q[i]} + (Y_W+2)'(HIT_WIN)) >= (Y_W+2)'(HIT_Y)) &&
                         ({2'b0, y_q[i]} <= (Y_W+2)'(HIT_Y + HIT_WIN));
            if (active) begin
                case (state_q[i])
                    IDLE: begin
`ifdef NOTE_LANE_BADPRESS_MISS_EN
                        if (btn_rise[i]) miss_d[i] = 1'b1;
`endif
                        if (spawn[i]) begin
                            state_d[i] = FALL;
                            y_d[i]     = '0;
                        end
                    end
                    FALL: begin
                        if (btn_rise[i] && in_win[i]) begin
                            hit_d[i]   = 1'b1;
                            state_d[i] = IDLE;
                        end else begin
`ifdef NOTE_LANE_BADPRESS_MISS_EN
                            if (btn_rise[i]) miss_d[i] = 1'b1;
`endif
                            if (tick) begin
                                if (y_next[i] >= (Y_W+1)'(SCREEN_H)) begin
                                    miss_d[i]  = 1'b1;
                                    state_d[i] = IDLE;
                                end else begin
                                    y_d[i] = y_next[i][Y_W-1:0];
                                end
                            end
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    // Note pixel per lane: inside the lane columns and the note's vertical span.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_pix_d[i] = video_on && (state_q[i] == FALL) &&
                            (px >= (Y_W+1)'(LANE_X0 + i * LANE_W)) &&
                            (px <  (Y_W+1)'(LANE_X0 + (i + 1) * LANE_W)) &&
                            (py >= {1'b0, y_q[i]}) &&
                            (py <  ({1'b0, y_q[i]} + (Y_W+1)'(NOTE_H)));
        end
    end

    // Saturating score and miss counters; lost follows the miss count by one cycle.
    always_comb begin
        score_sum  = {1'b0, score_q} + (SCORE_W+1)'(popcount(hit_d));
        score_d    = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        mc_sum     = miss_cnt_q + MC_W'(popcount(miss_d));
        miss_cnt_d = (mc_sum >= MC_W'(MAX_MISS)) ? MC_W'(MAX_MISS) : mc_sum;
        lost_d     = lost_q | (miss_cnt_q >= MC_W'(MAX_MISS));
    end

    // State register for lanes, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= IDLE;
                y_q[i]     <= '0;
            end
            button_q   <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            lane_pix_q <= '0;
            score_q    <= '0;
            miss_cnt_q <= '0;
            lost_q     <= 1'b0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                state_q[i] <= state_d[i];
                y_q[i]     <= y_d[i];
            end
            button_q   <= button;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            lane_pix_q <= lane_pix_d;
            score_q    <= score_d;
            miss_cnt_q <= miss_cnt_d;
            lost_q     <= lost_d;
        end
    end

    assign lane_pix = lane_pix_q;
    assign hit      = hit_q;
    assign miss     = miss_q;
    assign score    = score_q;
    assign lost     = lost_q;

    for (genvar g = 0; g < LANES; g++) begin : g_dbg
        assign dbg_state_o[g]          = (state_q[g] == FALL);
        assign dbg_y_o[g*Y_W +: Y_W]   = y_q[g];
    end

endmodule

// File: tb/tb_note_lane_engine.sv
`timescale 1ns/1ps
// Testbench for note_lane_engine: scenario tasks with a hit/miss event
// scoreboard checked by a monitor on the falling clock edge.
module tb_note_lane_engine;
  localparam int LANES    = 5;
  localparam int Y_W      = 10;
  localparam int SCORE_W  = 12;
  localparam int MAX_MISS = 8;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 tick;
  logic [1:0]           level;
  logic [LANES-1:0]     spawn;
  logic [LANES-1:0]     button;
  logic                 video_on;
  logic [Y_W-1:0]       pixel_x;
  logic [Y_W-1:0]       pixel_y;
  logic [LANES-1:0]     lane_pix;
  logic [LANES-1:0]     hit;
  logic [LANES-1:0]     miss;
  logic [SCORE_W-1:0]   score;
  logic                 lost;
  logic [LANES-1:0]     dbg_state;
  logic [LANES*Y_W-1:0] dbg_y;

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_score = 0;
  int exp_miss_cnt = 0;
  logic [2*LANES-1:0] exp_q[$];

  note_lane_engine dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick), .level(level),
    .spawn(spawn), .button(button), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .lane_pix(lane_pix), .hit(hit), .miss(miss), .score(score), .lost(lost),
    .dbg_state_o(dbg_state), .dbg_y_o(dbg_y)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

  // scoreboard monitor: every hit/miss pulse must match the next expected event
  always @(negedge clk) begin
    logic [2*LANES-1:0] e;
    if (!reset && ((hit | miss) != '0)) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got hit=%b miss=%b, required no event", hit, miss);
      end else begin
        e = exp_q.pop_front();
        if ({hit, miss} !== e) begin
          n_fail++;
          $display("FAIL sb_event: got hit=%b miss=%b, required hit=%b miss=%b",
                   hit, miss, e[2*LANES-1:LANES], e[LANES-1:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic spawn_lanes(input logic [LANES-1:0] m);
    spawn = m;
    cyc();
    spawn = '0;
  endtask

  task automatic press(input logic [LANES-1:0] m);
    button = m;
    cyc();
    button = '0;
  endtask

  function automatic logic [Y_W-1:0] lane_y(input int i);
    return dbg_y[i*Y_W +: Y_W];
  endfunction

  function automatic int pc(input logic [LANES-1:0] m);
    int c = 0;
    for (int k = 0; k < LANES; k++) c += int'(m[k]);
    return c;
  endfunction

  function automatic int sat_miss(input int v);
    return (v > MAX_MISS) ? MAX_MISS : v;
  endfunction

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; tick = 1'b0; level = 2'd0; spawn = '0; button = '0;
    video_on = 1'b0; pixel_x = '0; pixel_y = '0;
    cyc(); cyc();
    n_cmp++;
    if ({lane_pix, hit, miss, score, lost, dbg_state, dbg_y} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: pix=%b hit=%b miss=%b score=%0d lost=%b st=%b y=%h, required all 0",
               lane_pix, hit, miss, score, lost, dbg_state, dbg_y);
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_hit();
    level = 2'd0; video_on = 1'b1; pixel_x = 10'd300; pixel_y = 10'd390;
    spawn_lanes(5'b00100);
    n_cmp++;
    if (dbg_state !== 5'b00100 || lane_y(2) !== 10'd0) begin
      n_fail++;
      $display("FAIL hit_spawn: st=%b y=%0d, required st=00100 y=0", dbg_state, lane_y(2));
    end
    do_ticks(50);
    spawn_lanes(5'b00100);
    n_cmp++;
    if (lane_y(2) !== 10'd200) begin
      n_fail++;
      $display("FAIL spawn_in_fall: y=%0d, required 200", lane_y(2));
    end
    do_ticks(46);
    n_cmp++;
    if (lane_y(2) !== 10'd384 || lane_pix !== 5'b00100) begin
      n_fail++;
      $display("FAIL hit_pre: y=%0d pix=%b, required y=384 pix=00100", lane_y(2), lane_pix);
    end
    exp_q.push_back({5'b00100, 5'b00000});
    press(5'b00100);
    exp_score = 1;
    n_cmp++;
    if (hit !== 5'b00100 || score !== 12'd1 || dbg_state !== 5'b00000) begin
      n_fail++;
      $display("FAIL hit_pulse: hit=%b score=%0d st=%b, required hit=00100 score=1 st=0",
               hit, score, dbg_state);
    end
    cyc();
    n_cmp++;
    if (hit !== 5'b0 || lane_pix !== 5'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL hit_after: hit=%b pix=%b pending=%0d, required 0/0/0", hit, lane_pix, exp_q.size());
    end
  endtask

  task automatic test_reset_midfall();
    level = 2'd0;
    spawn_lanes(5'b00010);
    do_ticks(10);
    reset = 1'b1;
    cyc();
    n_cmp++;
    if ({lane_pix, hit, miss, score, lost, dbg_state, dbg_y} !== '0) begin
      n_fail++;
      $display("FAIL reset_midfall: pix=%b score=%0d st=%b y=%h, required all 0",
               lane_pix, score, dbg_state, dbg_y);
    end
    cyc();
    reset = 1'b0;
    exp_score = 0;
    exp_miss_cnt = 0;
    cyc();
  endtask

  task automatic test_miss();
    level = 2'd2;
    spawn_lanes(5'b00001);
    do_ticks(39);
    n_cmp++;
    if (lane_y(0) !== 10'd468 || miss !== 5'b0) begin
      n_fail++;
      $display("FAIL miss_pre: y=%0d miss=%b, required y=468 miss=0", lane_y(0), miss);
    end
    exp_q.push_back({5'b00000, 5'b00001});
    do_ticks(1);
    exp_miss_cnt = sat_miss(exp_miss_cnt + 1);
    n_cmp++;
    if (miss !== 5'b00001 || score !== SCORE_W'(exp_score) || dbg_state !== 5'b0) begin
      n_fail++;
      $display("FAIL miss_pulse: miss=%b score=%0d st=%b, required miss=00001 score=%0d st=0",
               miss, score, dbg_state, exp_score);
    end
    cyc();
    n_cmp++;
    if (miss !== 5'b0 || lost !== 1'b0) begin
      n_fail++;
      $display("FAIL miss_after: miss=%b lost=%b, required 0/0", miss, lost);
    end
  endtask

  task automatic test_boundary();
    int    ticks[4] = '{92, 100, 91, 101};
    logic  want[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    int    y;
    level = 2'd0;
    for (int c = 0; c < 4; c++) begin
      y = 4 * ticks[c];
      spawn_lanes(5'b00100);
      do_ticks(ticks[c]);
      if (want[c]) begin
        exp_q.push_back({5'b00100, 5'b00000});
        press(5'b00100);
        exp_score++;
        n_cmp++;
        if (hit !== 5'b00100 || dbg_state !== 5'b0 || score !== SCORE_W'(exp_score)) begin
          n_fail++;
          $display("FAIL boundary_hit y=%0d: hit=%b st=%b score=%0d, required hit=00100 st=0 score=%0d",
                   y, hit, dbg_state, score, exp_score);
        end
      end else begin
`ifdef NOTE_LANE_BADPRESS_MISS_EN
        exp_q.push_back({5'b00000, 5'b00100});
        exp_miss_cnt = sat_miss(exp_miss_cnt + 1);
`endif
        press(5'b00100);
        n_cmp++;
`ifdef NOTE_LANE_BADPRESS_MISS_EN
        if (hit !== 5'b0 || miss !== 5'b00100 || dbg_state !== 5'b00100) begin
`else
        if (hit !== 5'b0 || miss !== 5'b0 || dbg_state !== 5'b00100) begin
`endif
          n_fail++;
          $display("FAIL boundary_nohit y=%0d: hit=%b miss=%b st=%b", y, hit, miss, dbg_state);
        end
        // let the note fall off the bottom
        do_ticks((480 - y + 3) / 4 - 1);
        exp_q.push_back({5'b00000, 5'b00100});
        do_ticks(1);
        exp_miss_cnt = sat_miss(exp_miss_cnt + 1);
        n_cmp++;
        if (miss !== 5'b00100 || dbg_state !== 5'b0) begin
          n_fail++;
          $display("FAIL boundary_cleanup y=%0d: miss=%b st=%b, required miss=00100 st=0",
                   y, miss, dbg_state);
        end
      end
      cyc();
    end
  endtask

  task automatic test_simultaneous();
    level = 2'd0;
    spawn_lanes(5'b00100);
    do_ticks(95);
    exp_q.push_back({5'b00100, 5'b00000});
    button = 5'b00100; tick = 1'b1;
    cyc();
    button = '0; tick = 1'b0;
    exp_score++;
    n_cmp++;
    if (hit !== 5'b00100 || lane_y(2) !== 10'd380 || dbg_state !== 5'b0) begin
      n_fail++;
      $display("FAIL simul_tick: hit=%b y=%0d st=%b, required hit=00100 y=380 st=0",
               hit, lane_y(2), dbg_state);
    end
    spawn_lanes(5'b01010);
    do_ticks(96);
    exp_q.push_back({5'b01010, 5'b00000});
    press(5'b01010);
    exp_score += 2;
    n_cmp++;
    if (hit !== 5'b01010 || score !== SCORE_W'(exp_score)) begin
      n_fail++;
      $display("FAIL two_lane_hit: hit=%b score=%0d, required hit=01010 score=%0d", hit, score, exp_score);
    end
    // press on an idle lane
`ifdef NOTE_LANE_BADPRESS_MISS_EN
    exp_q.push_back({5'b00000, 5'b10000});
    exp_miss_cnt = sat_miss(exp_miss_cnt + 1);
`endif
    press(5'b10000);
    n_cmp++;
`ifdef NOTE_LANE_BADPRESS_MISS_EN
    if (hit !== 5'b0 || miss !== 5'b10000) begin
`else
    if (hit !== 5'b0 || miss !== 5'b0) begin
`endif
      n_fail++;
      $display("FAIL idle_press: hit=%b miss=%b", hit, miss);
    end
    cyc();
  endtask

  task automatic test_score_saturation();
    logic [LANES-1:0] m;
    int need;
    level = 2'd2;
    while (exp_score < SCORE_MAX) begin
      need = SCORE_MAX - exp_score;
      m = (need >= LANES) ? '1 : LANES'((1 << need) - 1);
      spawn_lanes(m);
      do_ticks(31);
      exp_q.push_back({m, 5'b00000});
      press(m);
      exp_score += pc(m);
      n_cmp++;
      if (score !== SCORE_W'(exp_score)) begin
        n_fail++;
        $display("FAIL score_accum: score=%0d, required %0d", score, exp_score);
      end
    end
    spawn_lanes(5'b00001);
    do_ticks(31);
    exp_q.push_back({5'b00001, 5'b00000});
    press(5'b00001);
    cyc();
    n_cmp++;
    if (score !== SCORE_W'(SCORE_MAX)) begin
      n_fail++;
      $display("FAIL score_sat: score=%0d, required %0d", score, SCORE_MAX);
    end
  endtask

  task automatic test_lost_freeze();
    logic fin;
    level = 2'd2;
    fin = 1'b0;
    while (!fin) begin
      fin = (exp_miss_cnt + 4 >= MAX_MISS);
      spawn_lanes(5'b11110);
      if (fin) begin
        do_ticks(10);
        spawn_lanes(5'b00001);
        do_ticks(29);
      end else begin
        do_ticks(39);
      end
      exp_q.push_back({5'b00000, 5'b11110});
      do_ticks(1);
      exp_miss_cnt = sat_miss(exp_miss_cnt + 4);
      n_cmp++;
      if (miss !== 5'b11110 || lost !== 1'b0) begin
        n_fail++;
        $display("FAIL lost_round: miss=%b lost=%b, required miss=11110 lost=0", miss, lost);
      end
    end
    cyc();
    n_cmp++;
    if (lost !== 1'b1 || lane_y(0) !== 10'd360 || dbg_state !== 5'b00001) begin
      n_fail++;
      $display("FAIL lost_set: lost=%b y0=%0d st=%b, required lost=1 y0=360 st=00001",
               lost, lane_y(0), dbg_state);
    end
    // frozen: spawn, ticks and presses do nothing
    spawn = '1; tick = 1'b1; button = 5'b00001;
    repeat (5) cyc();
    spawn = '0; tick = 1'b0; button = '0;
    cyc();
    n_cmp++;
    if (lane_y(0) !== 10'd360 || dbg_state !== 5'b00001 || lost !== 1'b1 ||
        score !== SCORE_W'(SCORE_MAX)) begin
      n_fail++;
      $display("FAIL freeze: y0=%0d st=%b lost=%b score=%0d, required 360/00001/1/%0d",
               lane_y(0), dbg_state, lost, score, SCORE_MAX);
    end
    // pixels keep drawing while lost: lane 0 note spans y 360..391
    video_on = 1'b1; pixel_x = 10'd100;
    pixel_y = 10'd360; cyc();
    n_cmp++;
    if (lane_pix !== 5'b00001) begin
      n_fail++; $display("FAIL pix_top: pix=%b, required 00001", lane_pix);
    end
    pixel_y = 10'd359; cyc();
    n_cmp++;
    if (lane_pix !== 5'b00000) begin
      n_fail++; $display("FAIL pix_above: pix=%b, required 00000", lane_pix);
    end
    pixel_y = 10'd391; cyc();
    n_cmp++;
    if (lane_pix !== 5'b00001) begin
      n_fail++; $display("FAIL pix_bottom: pix=%b, required 00001", lane_pix);
    end
    pixel_y = 10'd392; cyc();
    n_cmp++;
    if (lane_pix !== 5'b00000) begin
      n_fail++; $display("FAIL pix_below: pix=%b, required 00000", lane_pix);
    end
    pixel_y = 10'd370; pixel_x = 10'd160; cyc();
    n_cmp++;
    if (lane_pix !== 5'b00000) begin
      n_fail++; $display("FAIL pix_x_edge: pix=%b, required 00000", lane_pix);
    end
    pixel_x = 10'd159; video_on = 1'b0; cyc();
    n_cmp++;
    if (lane_pix !== 5'b00000) begin
      n_fail++; $display("FAIL pix_video_off: pix=%b, required 00000", lane_pix);
    end
  endtask

  initial begin
    test_reset();
    test_hit();
    test_reset_midfall();
    test_miss();
    test_boundary();
    test_simultaneous();
    test_score_saturation();
    test_lost_freeze();
    cyc();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
